// File: rtl/aes_fwd_shift_mix.sv
// aes_fwd_shift_mix
//   Column-serial forward AES diffusion: ShiftRows followed by an optional
//   MixColumns, COLS_PER_CYCLE columns per clock through shared mix logic.
//   State is column-major: byte k = data[127-8k -: 8], byte (r,c) = byte 4c+r.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active-high
//   in_valid   in   data_i / bypass_mix valid
//   in_ready   out  block can accept (IDLE and not in reset)
//   data_i     in   128-bit input state
//   bypass_mix in   1 = ShiftRows only, 0 = ShiftRows + MixColumns
//   out_valid  out  data_o holds a complete result
//   out_ready  in   downstream accepts data_o
//   data_o     out  128-bit registered result
module aes_fwd_shift_mix #(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_i,
  input  logic         bypass_mix,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_o
);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("aes_fwd_shift_mix: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter step wraps to 0 when four columns are done in one cycle.
  localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYCLE);

  state_t                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [0:15][7:0]      hold_q, hold_d;   // element k is byte k
  logic                  byp_q, byp_d;
  logic [0:3][31:0]      data_q, data_d;   // element c is column c
  logic [0:3][0:3][7:0]  sr_col;           // ShiftRows view: [column][row]

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] s0, s1, s2, s3;
    s0 = col[31:24];
    s1 = col[23:16];
    s2 = col[15:8];
    s3 = col[7:0];
    return {xtime(s0) ^ xtime(s1) ^ s1 ^ s2 ^ s3,
            s0 ^ xtime(s1) ^ xtime(s2) ^ s2 ^ s3,
            s0 ^ s1 ^ xtime(s2) ^ xtime(s3) ^ s3,
            xtime(s0) ^ s0 ^ s1 ^ s2 ^ xtime(s3)};
  endfunction

  // ShiftRows is pure wiring: out(r,c) = in(r,(c+r) mod 4).
  for (genvar c = 0; c < 4; c++) begin : g_sr_c
    for (genvar r = 0; r < 4; r++) begin : g_sr_r
      assign sr_col[c][r] = hold_q[4*((c+r)%4)+r];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      byp_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      byp_q   <= byp_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    byp_d   = byp_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          hold_d  = data_i;
          byp_d   = bypass_mix;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Bypass still spends the same cycles so latency is data-independent.
        for (int unsigned j = 0; j < COLS_PER_CYCLE; j++) begin
          data_d[cnt_q + 2'(j)] = byp_q ? sr_col[cnt_q + 2'(j)]
                                        : mix_col(sr_col[cnt_q + 2'(j)]);
        end
        cnt_d = cnt_q + STEP;
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign data_o    = data_q;

endmodule

// File: tb/tb_aes_fwd_shift_mix.sv
// Self-checking bench for aes_fwd_shift_mix: three instances (1, 2 and 4
// columns per cycle) share data/bypass/reset, each with its own handshake.
module tb_aes_fwd_shift_mix;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] din;
  logic         byp;
  logic         iv   [3];
  logic         ordy [3];
  logic         ir   [3];
  logic         ov   [3];
  logic [127:0] dout [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  aes_fwd_shift_mix #(.COLS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .data_i(din),
    .bypass_mix(byp), .out_valid(ov[0]), .out_ready(ordy[0]), .data_o(dout[0]));
  aes_fwd_shift_mix #(.COLS_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .data_i(din),
    .bypass_mix(byp), .out_valid(ov[1]), .out_ready(ordy[1]), .data_o(dout[1]));
  aes_fwd_shift_mix #(.COLS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .data_i(din),
    .bypass_mix(byp), .out_valid(ov[2]), .out_ready(ordy[2]), .data_o(dout[2]));

  // ---------------- reference model (byte arrays + generic GF multiply) ----
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // dir=+1: out(r,c)=in(r,c+r); dir=-1: out(r,c)=in(r,c-r)
  function automatic logic [127:0] shift_rows(input logic [127:0] d, input int dir);
    logic [127:0] o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = d[127-8*(4*((c+dir*r+4)%4)+r) -: 8];
    return o;
  endfunction

  // Circulant matrix whose first row is coef bytes m0..m3.
  function automatic logic [127:0] mix(input logic [127:0] d, input logic [31:0] coef);
    logic [127:0] o = '0;
    logic [7:0]   acc;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = '0;
        for (int i = 0; i < 4; i++)
          acc ^= gmul(coef[31-8*((i-r+4)%4) -: 8], d[127-8*(4*c+i) -: 8]);
        o[127-8*(4*c+r) -: 8] = acc;
      end
    return o;
  endfunction

  function automatic logic [127:0] ref_fwd(input logic [127:0] d, input logic b);
    logic [127:0] t = shift_rows(d, 1);
    return b ? t : mix(t, 32'h02030101);
  endfunction

  function automatic logic [127:0] ref_inv(input logic [127:0] d);
    return shift_rows(mix(d, 32'h0e0b0d09), -1);
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transaction on instance k with latency L; optional DONE hold time and
  // garbage pokes on in_valid/data_i while the block is busy.
  task automatic run_item(input int k, input logic [127:0] d, input logic b,
                          input logic [127:0] exp, input int L, input int hold,
                          input bit poke, input string tag);
    int n;
    @(negedge clk);
    chk({tag, ":in_ready"}, 128'(ir[k]), 128'(1));
    din = d; byp = b; iv[k] = 1'b1;
    @(posedge clk); #1;
    iv[k] = 1'b0;
    n = 0;
    while (!ov[k] && n < 20) begin
      if (poke) begin din = rnd128(); byp = ~byp; iv[k] = 1'b1; end
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ":latency"}, 128'(n), 128'(L));
    chk({tag, ":data"}, dout[k], exp);
    chk({tag, ":busy_rdy"}, 128'(ir[k]), 128'(0));
    if (!b) chk({tag, ":roundtrip"}, ref_inv(dout[k]), d);
    for (int h = 0; h < hold; h++) begin
      if (poke) begin din = rnd128(); byp = ~byp; iv[k] = 1'b1; end
      @(posedge clk); #1;
      chk({tag, ":hold_valid"}, 128'(ov[k]), 128'(1));
      chk({tag, ":hold_data"}, dout[k], exp);
      chk({tag, ":hold_rdy"}, 128'(ir[k]), 128'(0));
    end
    iv[k] = 1'b0;
    ordy[k] = 1'b1;
    @(posedge clk); #1;
    ordy[k] = 1'b0;
    chk({tag, ":post_valid"}, 128'(ov[k]), 128'(0));
    chk({tag, ":post_rdy"}, 128'(ir[k]), 128'(1));
  endtask

  localparam logic [127:0] FIPS_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] FIPS_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;

  initial begin
    logic [127:0] vec [8];
    logic [127:0] expq [8];
    logic [127:0] d, od;
    logic         b, acc, outv;
    int ai, oi, cyc, last;

    rst = 1'b1; din = '0; byp = 1'b0;
    for (int k = 0; k < 3; k++) begin iv[k] = 1'b0; ordy[k] = 1'b0; end

    // reset state
    #12;
    for (int k = 0; k < 3; k++) begin
      chk("rst_in_ready", 128'(ir[k]), 128'(0));
      chk("rst_out_valid", 128'(ov[k]), 128'(0));
      chk("rst_data", dout[k], '0);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) chk("rel_in_ready", 128'(ir[k]), 128'(1));

    // directed vectors
    run_item(0, 128'h000102030405060708090a0b0c0d0e0f, 1'b1,
             128'h00050a0f04090e03080d02070c01060b, 4, 0, 0, "bypass_c1");
    run_item(0, FIPS_IN, 1'b0, FIPS_OUT, 4, 0, 0, "fips_c1");
    run_item(1, FIPS_IN, 1'b0, FIPS_OUT, 2, 0, 0, "fips_c2");
    run_item(2, FIPS_IN, 1'b0, FIPS_OUT, 1, 0, 0, "fips_c4");

    // backpressure with ignored inputs during BUSY and DONE
    d = rnd128();
    run_item(0, d, 1'b0, ref_fwd(d, 1'b0), 4, 10, 1, "bp_c1");
    d = rnd128();
    run_item(2, d, 1'b1, ref_fwd(d, 1'b1), 1, 3, 1, "bp_c4");

    // random round-trip and model checks
    for (int i = 0; i < 200; i++) begin
      d = rnd128();
      run_item(0, d, 1'b0, ref_fwd(d, 1'b0), 4, 0, 0, "rand_c1");
    end
    for (int i = 0; i < 20; i++) begin
      d = rnd128(); b = 1'($urandom_range(0, 1));
      run_item(1, d, b, ref_fwd(d, b), 2, 0, 0, "rand_c2");
      d = rnd128(); b = 1'($urandom_range(0, 1));
      run_item(2, d, b, ref_fwd(d, b), 1, 0, 0, "rand_c4");
    end

    // back-to-back on the single-column instance: interval L+2 = 6
    for (int i = 0; i < 8; i++) begin
      vec[i] = rnd128() ^ 128'(i);
      expq[i] = ref_fwd(vec[i], 1'b0);
    end
    byp = 1'b0; ordy[0] = 1'b1;
    ai = 0; oi = 0; cyc = 0; last = 0;
    while ((ai < 8 || oi < 8) && cyc < 200) begin
      @(negedge clk);
      din = vec[(ai < 8) ? ai : 7];
      iv[0] = (ai < 8);
      acc = iv[0] && ir[0];
      outv = ov[0];
      od = dout[0];
      @(posedge clk);
      cyc++;
      if (acc) begin
        if (ai > 0) chk("b2b_interval", 128'(cyc - last), 128'(6));
        last = cyc;
        ai++;
      end
      if (outv && oi < 8) begin
        chk("b2b_order", od, expq[oi]);
        oi++;
      end
    end
    chk("b2b_accepts", 128'(ai), 128'(8));
    chk("b2b_outputs", 128'(oi), 128'(8));
    @(negedge clk); iv[0] = 1'b0; ordy[0] = 1'b0;

    // reset two cycles after accept aborts the operation
    @(negedge clk);
    din = rnd128(); byp = 1'b0; iv[0] = 1'b1;
    @(posedge clk); #1; iv[0] = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("abort_valid", 128'(ov[k]), 128'(0));
      chk("abort_data", dout[k], '0);
      chk("abort_rdy", 128'(ir[k]), 128'(0));
    end
    @(negedge clk); rst = 1'b0;
    run_item(0, FIPS_IN, 1'b0, FIPS_OUT, 4, 0, 0, "after_rst_c1");
    d = rnd128();
    run_item(1, d, 1'b0, ref_fwd(d, 1'b0), 2, 0, 0, "after_rst_c2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
